// File: rtl/ahb_pkg.sv
// AHB transfer and response encodings shared by the AXI2AHB bridge response path.
// Pure types and helpers; no latency, no backpressure.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  function automatic resp_t err_to_resp(input logic err);
    return err ? SLVERR : OKAY;
  endfunction

endpackage

// File: rtl/ahb_read_packer.sv
// Packs consecutive narrow AHB read beats into one AXI R beat, tracking per-beat error status.
// Push strobe is combinational with the completing beat; the caller gates beats on R queue space.
module ahb_read_packer
  import ahb_pkg::*;
#(
  parameter int AHB_DATA_WIDTH = 32,
  parameter int DW = 64,
  localparam int RATIO = DW / AHB_DATA_WIDTH,
  localparam int LANEW = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      rbeat,
  input  logic [AHB_DATA_WIDTH-1:0] HRDATA,
  input  logic                      r_last_beat,
  input  logic [LANEW-1:0]          r_start_lane,
  input  logic                      err_capture,
  output logic                      lane_complete,
  output logic                      push,
  output logic [DW-1:0]             push_data,
  output resp_t                     push_resp
);

  logic                                active;
  logic [LANEW-1:0]                    lane_cnt, cur_lane, next_lane;
  logic [RATIO-1:0][AHB_DATA_WIDTH-1:0] pack_q, pack_merged;
  logic                                err_r;

  // r_start_lane only matters on the first beat of a burst.
  assign cur_lane      = (RATIO == 1) ? '0 : (active ? lane_cnt : r_start_lane);
  assign next_lane     = (cur_lane == LANEW'(RATIO - 1)) ? '0 : cur_lane + LANEW'(1);
  assign lane_complete = (cur_lane == LANEW'(RATIO - 1)) || r_last_beat;
  assign push          = rbeat && lane_complete;
  assign push_data     = pack_merged;
  assign push_resp     = err_to_resp(err_r);

  always_comb begin
    pack_merged = pack_q;
    for (int i = 0; i < RATIO; i++) begin
      if (LANEW'(i) == cur_lane) pack_merged[i] = HRDATA;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      active   <= 1'b0;
      lane_cnt <= '0;
      pack_q   <= '0;
      err_r    <= 1'b0;
    end else begin
      if (rbeat) begin
        lane_cnt <= next_lane;
        active   <= !r_last_beat;
        pack_q   <= push ? '0 : pack_merged;
      end
      // An error landing with the push belongs to the next AXI beat.
      err_r <= push ? err_capture : (err_r | err_capture);
    end
  end

endmodule

// File: rtl/fifo_duth.sv
// Generic synchronous FIFO; push visible on pop side the cycle after the push edge.
// push_rdy is !full (no fall-through); a push together with a pop is accepted even when full.
module fifo_duth #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  input  logic             pop,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign push_rdy = (cnt != CW'(DEPTH));
  assign pop_vld  = (cnt != '0);
  assign do_pop   = pop && pop_vld;
  assign do_push  = push && (push_rdy || do_pop);
  assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; pop_dat is gated by pop_vld instead.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ahb_resp_packer.sv
// AHB-to-AXI B/R response path: packs narrow read beats, tracks errors, queues B and R responses.
// Valid one cycle after push; full R queue stalls only lane-completing beats, B overflow is illegal.
module ahb_resp_packer
  import ahb_pkg::*;
#(
  parameter int AHB_DATA_WIDTH = 32,
  parameter int DW = 64,
  parameter int TIDW = 1,
  parameter int USERW = 1,
  parameter int B_QUEUE_SLOTS = 4,
  parameter int R_QUEUE_SLOTS = 4,
  localparam int RATIO = DW / AHB_DATA_WIDTH,
  localparam int LANEW = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HREADY,
  input  logic                      HRESP,
  input  state_t                    HTRANS,
  input  logic [AHB_DATA_WIDTH-1:0] HRDATA,
  input  logic                      pending_read,
  input  logic                      waiting_for_ahb_slave_response,
  input  logic                      r_last_beat,
  input  logic [LANEW-1:0]          r_start_lane,
  input  logic [TIDW-1:0]           TID_queue_data,
  output logic                      TID_queue_pop,
  output logic                      reset_pending_read,
  output logic                      reset_waiting_ahb_slave_response,
  output logic                      write_b_ack,
  output logic                      read_queue_ready,
  output logic [TIDW-1:0]           axi_b_id_o,
  output logic [1:0]                axi_b_resp_o,
  output logic [USERW-1:0]          axi_b_user_o,
  output logic                      axi_b_valid_o,
  input  logic                      axi_b_ready_i,
  output logic [TIDW-1:0]           axi_r_id_o,
  output logic [DW-1:0]             axi_r_data_o,
  output logic [1:0]                axi_r_resp_o,
  output logic                      axi_r_last_o,
  output logic [USERW-1:0]          axi_r_user_o,
  output logic                      axi_r_valid_o,
  input  logic                      axi_r_ready_i
);

  typedef struct packed {
    logic [TIDW-1:0] id;
    resp_t           resp;
  } b_ent_t;

  typedef struct packed {
    logic [TIDW-1:0] id;
    logic [DW-1:0]   data;
    resp_t           resp;
    logic            last;
  } r_ent_t;

  b_ent_t b_in, b_out;
  r_ent_t r_in, r_out;
  logic   b_push, b_pop, b_q_rdy;
  logic   r_push, r_pop, r_q_rdy;
  logic   rbeat, lane_complete, err_b;
  logic [DW-1:0] pack_data;
  resp_t  pack_resp;

  assign read_queue_ready = lane_complete ? r_q_rdy : 1'b1;
  assign rbeat  = !HRESET && pending_read && HREADY && read_queue_ready;
  assign b_push = !HRESET && waiting_for_ahb_slave_response && HREADY;

  ahb_read_packer #(
    .AHB_DATA_WIDTH (AHB_DATA_WIDTH),
    .DW             (DW)
  ) u_read_packer (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .rbeat         (rbeat),
    .HRDATA        (HRDATA),
    .r_last_beat   (r_last_beat),
    .r_start_lane  (r_start_lane),
    .err_capture   (pending_read && !HREADY && HRESP),
    .lane_complete (lane_complete),
    .push          (r_push),
    .push_data     (pack_data),
    .push_resp     (pack_resp)
  );

  // Captured on the first (HREADY low) cycle of the two-cycle AHB error response.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_b <= 1'b0;
    end else if (b_push) begin
      err_b <= 1'b0;
    end else if (waiting_for_ahb_slave_response && !HREADY && HRESP) begin
      err_b <= 1'b1;
    end
  end

  assign b_in = '{id: TID_queue_data, resp: err_to_resp(err_b)};
  assign r_in = '{id: TID_queue_data, data: pack_data, resp: pack_resp, last: r_last_beat};

  fifo_duth #(
    .WIDTH ($bits(b_ent_t)),
    .DEPTH (B_QUEUE_SLOTS)
  ) u_b_queue (
    .clk      (HCLK),
    .rst      (HRESET),
    .push     (b_push),
    .push_dat (b_in),
    .push_rdy (b_q_rdy),
    .pop      (b_pop),
    .pop_vld  (axi_b_valid_o),
    .pop_dat  (b_out)
  );

  fifo_duth #(
    .WIDTH ($bits(r_ent_t)),
    .DEPTH (R_QUEUE_SLOTS)
  ) u_r_queue (
    .clk      (HCLK),
    .rst      (HRESET),
    .push     (r_push),
    .push_dat (r_in),
    .push_rdy (r_q_rdy),
    .pop      (r_pop),
    .pop_vld  (axi_r_valid_o),
    .pop_dat  (r_out)
  );

  assign b_pop        = axi_b_valid_o && axi_b_ready_i;
  assign write_b_ack  = b_pop;
  assign axi_b_id_o   = b_out.id;
  assign axi_b_resp_o = b_out.resp;
  assign axi_b_user_o = '0;

  assign r_pop        = axi_r_valid_o && axi_r_ready_i;
  assign axi_r_id_o   = r_out.id;
  assign axi_r_data_o = r_out.data;
  assign axi_r_resp_o = r_out.resp;
  assign axi_r_last_o = r_out.last;
  assign axi_r_user_o = '0;

  assign TID_queue_pop                    = b_push || (r_push && r_last_beat);
  assign reset_pending_read               = r_push && r_last_beat;
  assign reset_waiting_ahb_slave_response = HREADY && (HTRANS != BUSY);

  // Upstream bounds outstanding writes, so a push into a full B queue is a protocol bug.
  b_queue_overflow : assert property (@(posedge HCLK) disable iff (HRESET)
    !(b_push && !b_q_rdy && !b_pop));

endmodule

// File: tb/tb_ahb_resp_packer.sv
// Randomized scoreboard bench for ahb_resp_packer: burst-level packing model feeds expected queues,
// an independent monitor pops and compares on every B/R handshake.
module tb_ahb_resp_packer;
  import ahb_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int RATIO = DW / AW;
  localparam int LANEW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int TIDW  = 1;
  localparam int USERW = 1;
  localparam int BQ    = 4;
  localparam int RQ    = 4;

  logic             HCLK = 1'b0;
  logic             HRESET, HREADY, HRESP;
  state_t           HTRANS;
  logic [AW-1:0]    HRDATA;
  logic             pending_read, waiting_for_ahb_slave_response, r_last_beat;
  logic [LANEW-1:0] r_start_lane;
  logic [TIDW-1:0]  TID_queue_data;
  logic             TID_queue_pop, reset_pending_read, reset_waiting_ahb_slave_response;
  logic             write_b_ack, read_queue_ready;
  logic [TIDW-1:0]  axi_b_id_o, axi_r_id_o;
  logic [1:0]       axi_b_resp_o, axi_r_resp_o;
  logic [USERW-1:0] axi_b_user_o, axi_r_user_o;
  logic             axi_b_valid_o, axi_b_ready_i, axi_r_valid_o, axi_r_ready_i, axi_r_last_o;
  logic [DW-1:0]    axi_r_data_o;

  ahb_resp_packer #(
    .AHB_DATA_WIDTH (AW), .DW (DW), .TIDW (TIDW), .USERW (USERW),
    .B_QUEUE_SLOTS (BQ), .R_QUEUE_SLOTS (RQ)
  ) dut (
    .HCLK (HCLK), .HRESET (HRESET), .HREADY (HREADY), .HRESP (HRESP), .HTRANS (HTRANS),
    .HRDATA (HRDATA), .pending_read (pending_read),
    .waiting_for_ahb_slave_response (waiting_for_ahb_slave_response),
    .r_last_beat (r_last_beat), .r_start_lane (r_start_lane), .TID_queue_data (TID_queue_data),
    .TID_queue_pop (TID_queue_pop), .reset_pending_read (reset_pending_read),
    .reset_waiting_ahb_slave_response (reset_waiting_ahb_slave_response),
    .write_b_ack (write_b_ack), .read_queue_ready (read_queue_ready),
    .axi_b_id_o (axi_b_id_o), .axi_b_resp_o (axi_b_resp_o), .axi_b_user_o (axi_b_user_o),
    .axi_b_valid_o (axi_b_valid_o), .axi_b_ready_i (axi_b_ready_i),
    .axi_r_id_o (axi_r_id_o), .axi_r_data_o (axi_r_data_o), .axi_r_resp_o (axi_r_resp_o),
    .axi_r_last_o (axi_r_last_o), .axi_r_user_o (axi_r_user_o),
    .axi_r_valid_o (axi_r_valid_o), .axi_r_ready_i (axi_r_ready_i)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [DW-1:0]   data;
    logic [1:0]      resp;
    logic            last;
    logic [TIDW-1:0] id;
  } r_exp_t;

  typedef struct {
    logic [1:0]      resp;
    logic [TIDW-1:0] id;
  } b_exp_t;

  r_exp_t exp_r[$];
  b_exp_t exp_b[$];
  int n_chk = 0;
  int n_fail = 0;
  int r_pushed = 0;
  int r_popped = 0;
  int r_rdy_mode = 0;  // 0 random, 1 held low, 2 held high

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  initial begin
    axi_r_ready_i = 1'b0;
    axi_b_ready_i = 1'b0;
    forever begin
      @(posedge HCLK);
      #1;
      axi_b_ready_i = ($urandom_range(3) != 0);
      case (r_rdy_mode)
        0:       axi_r_ready_i = ($urandom_range(3) != 0);
        1:       axi_r_ready_i = 1'b0;
        default: axi_r_ready_i = 1'b1;
      endcase
    end
  end

  // Monitor: compares every handshake against the scoreboard and checks hold stability.
  r_exp_t        mon_r;
  b_exp_t        mon_b;
  logic          r_hold = 1'b0;
  logic [DW-1:0] r_prev = '0;
  always @(negedge HCLK) begin
    if (HRESET) begin
      r_hold = 1'b0;
    end else begin
      if (r_hold) begin
        chk("r_hold_valid", axi_r_valid_o, 1);
        chk("r_hold_data", axi_r_data_o, r_prev);
      end
      if (axi_r_valid_o && axi_r_ready_i) begin
        if (exp_r.size() == 0) begin
          chk("r_unexpected_beat", axi_r_data_o, 0);
          if (axi_r_data_o === '0) begin
            n_fail++;
            $display("FAIL r_unexpected_beat: got a beat, expected none at %0t", $time);
          end
        end else begin
          mon_r = exp_r.pop_front();
          chk("r_data", axi_r_data_o, mon_r.data);
          chk("r_resp", axi_r_resp_o, mon_r.resp);
          chk("r_last", axi_r_last_o, mon_r.last);
          chk("r_id", axi_r_id_o, mon_r.id);
        end
        r_popped++;
      end
      r_hold = axi_r_valid_o && !axi_r_ready_i;
      r_prev = axi_r_data_o;
      if (axi_b_valid_o && axi_b_ready_i) begin
        chk("b_ack", write_b_ack, 1);
        if (exp_b.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL b_unexpected: got resp %0h, expected none at %0t", axi_b_resp_o, $time);
        end else begin
          mon_b = exp_b.pop_front();
          chk("b_resp", axi_b_resp_o, mon_b.resp);
          chk("b_id", axi_b_id_o, mon_b.id);
        end
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_ahb();
    HREADY = 1'b1;
    HRESP = 1'b0;
    HTRANS = IDLE;
    pending_read = 1'b0;
    waiting_for_ahb_slave_response = 1'b0;
    r_last_beat = 1'b0;
  endtask

  // Expected AXI beats come from beat position arithmetic: beat k sits at absolute lane start+k.
  task automatic rd_burst(input int start, input int n, input logic [AW-1:0] d[16],
                          input bit e[16], input int waits_max);
    r_exp_t        ex[16];
    logic [DW-1:0] tmp;
    logic [TIDW-1:0] id;
    int nb, lane, stalls;
    bit lc, accepted;
    id = TIDW'($urandom);
    nb = (start + n - 1) / RATIO + 1;
    for (int j = 0; j < nb; j++) ex[j] = '{data: '0, resp: 2'b00, last: (j == nb - 1), id: id};
    for (int k = 0; k < n; k++) begin
      tmp = '0;
      tmp[AW-1:0] = d[k];
      ex[(start + k) / RATIO].data |= tmp << (((start + k) % RATIO) * AW);
      if (e[k]) ex[(start + k) / RATIO].resp = 2'b10;
    end
    for (int j = 0; j < nb; j++) exp_r.push_back(ex[j]);
    TID_queue_data = id;
    r_start_lane = LANEW'(start);
    for (int k = 0; k < n; k++) begin
      lane = (start + k) % RATIO;
      lc = (lane == RATIO - 1) || (k == n - 1);
      pending_read = 1'b1;
      HTRANS = (k == 0) ? NONSEQ : SEQ;
      if (e[k]) begin
        HREADY = 1'b0;
        HRESP = 1'b1;
        step();
      end
      repeat ($urandom_range(waits_max)) begin
        HREADY = 1'b0;
        HRESP = 1'b0;
        step();
      end
      HREADY = 1'b1;
      HRESP = e[k];
      HRDATA = d[k];
      r_last_beat = (k == n - 1);
      stalls = 0;
      accepted = 0;
      while (!accepted) begin
        @(negedge HCLK);
        if (!axi_r_ready_i)
          chk("read_queue_ready", read_queue_ready, !lc || (r_pushed - r_popped < RQ));
        if (read_queue_ready) begin
          chk("tid_pop_read", TID_queue_pop, k == n - 1);
          chk("reset_pending_read", reset_pending_read, k == n - 1);
          accepted = 1;
          if (lc) r_pushed++;
        end else begin
          stalls++;
          if (stalls == 6 && r_rdy_mode == 1) r_rdy_mode = 2;
          if (stalls > 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL read_stall_timeout: beat %0d never accepted, expected acceptance", k);
            accepted = 1;
          end
        end
        step();
      end
    end
    idle_ahb();
  endtask

  task automatic wr(input bit err, input int waits);
    b_exp_t be;
    int t;
    t = 0;
    while (exp_b.size() >= BQ && t < 200) begin
      step();
      t++;
    end
    be.id = TIDW'($urandom);
    be.resp = err ? 2'b10 : 2'b00;
    TID_queue_data = be.id;
    HTRANS = NONSEQ;
    waiting_for_ahb_slave_response = 1'b1;
    if (err) begin
      HREADY = 1'b0;
      HRESP = 1'b1;
      @(negedge HCLK);
      chk("tid_pop_err_cycle", TID_queue_pop, 0);
      step();
    end
    repeat (waits) begin
      HREADY = 1'b0;
      HRESP = 1'b0;
      step();
    end
    HREADY = 1'b1;
    HRESP = err;
    exp_b.push_back(be);
    @(negedge HCLK);
    chk("tid_pop_write", TID_queue_pop, 1);
    chk("reset_waiting", reset_waiting_ahb_slave_response, 1);
    step();
    idle_ahb();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0) && t < 2000) begin
      step();
      t++;
    end
    chk("r_outstanding", exp_r.size(), 0);
    chk("b_outstanding", exp_b.size(), 0);
  endtask

  logic [AW-1:0] d[16];
  bit            e[16];

  initial begin
    HRESET = 1'b1;
    HRDATA = '0;
    r_start_lane = '0;
    TID_queue_data = '0;
    idle_ahb();
    repeat (3) step();
    @(negedge HCLK);
    chk("reset_r_valid", axi_r_valid_o, 0);
    chk("reset_b_valid", axi_b_valid_o, 0);
    chk("reset_r_data", axi_r_data_o, 0);
    chk("reset_tid_pop", TID_queue_pop, 0);
    chk("reset_write_b_ack", write_b_ack, 0);
    chk("reset_read_queue_ready", read_queue_ready, 1);
    chk("reset_rst_wait", reset_waiting_ahb_slave_response, 1);
    step();
    HRESET = 1'b0;

    for (int i = 0; i < 16; i++) begin
      d[i] = '0;
      e[i] = 0;
    end
    d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33; d[3] = 32'h44;
    rd_burst(0, 4, d, e, 1);
    d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC;
    rd_burst(1, 3, d, e, 0);
    d[0] = 32'h1111; d[1] = 32'h2222; d[2] = 32'h3333; d[3] = 32'h4444;
    e[1] = 1;
    rd_burst(0, 4, d, e, 0);
    e[1] = 0;
    wr(1, 1);
    wr(0, 0);

    HTRANS = BUSY;
    HREADY = 1'b1;
    @(negedge HCLK);
    chk("rst_wait_busy", reset_waiting_ahb_slave_response, 0);
    HTRANS = NONSEQ;
    HREADY = 1'b0;
    #1;
    chk("rst_wait_not_ready", reset_waiting_ahb_slave_response, 0);
    step();
    idle_ahb();
    drain();

    // R queue full with AXI ready low: only lane-completing beats stall.
    r_rdy_mode = 1;
    repeat (2) step();
    for (int i = 0; i < 12; i++) d[i] = 32'h100 + AW'(i);
    rd_burst(0, 12, d, e, 0);
    r_rdy_mode = 0;
    drain();

    // Reset after one lane of a burst: the partial pack must vanish.
    pending_read = 1'b1;
    r_start_lane = '0;
    HRDATA = 32'h5555_5555;
    step();
    HRESET = 1'b1;
    idle_ahb();
    repeat (2) step();
    @(negedge HCLK);
    chk("midreset_r_valid", axi_r_valid_o, 0);
    step();
    HRESET = 1'b0;
    d[0] = 32'hCAFE; d[1] = 32'hBEEF; d[2] = 32'hF00D;
    rd_burst(1, 3, d, e, 0);
    drain();

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          d[i] = AW'($urandom);
          e[i] = ($urandom_range(7) == 0);
        end
        rd_burst($urandom_range(RATIO - 1), $urandom_range(8, 1), d, e, 2);
      end else begin
        wr($urandom_range(3) == 0, $urandom_range(2));
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
